// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the execute-side memory path: memOP codes, the
// memory-access FSM encoding and default timeout sizing.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MOP_NONE  = 2'd0,
        MOP_LOAD  = 2'd1,
        MOP_STORE = 2'd2,
        MOP_RSVD  = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int DEFAULT_CNTW    = 4;

    // Reserved code behaves like MOP_NONE: only load and store touch memory.
    function automatic logic is_access(input logic [1:0] op);
        return (op == MOP_LOAD) || (op == MOP_STORE);
    endfunction

endpackage

// File: rtl/mau_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request; expired flags the
// last cycle the request may still be acknowledged.
module mau_timeout_counter #(
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNTW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Single load/store engine between execute and the data-memory port;
// holds busy from acceptance until a one-cycle done/error pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int BITSADDR = 32,
    parameter int BITSDATA = 32,
    parameter int MEMOP    = 2,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int CNTW     = DEFAULT_CNTW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MEMOP-1:0]    memOP,
    input  logic [BITSADDR-1:0] address,
    input  logic [BITSDATA-1:0] storeData,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [BITSDATA-1:0] loadData,
    output logic                mem_req,
    output logic                mem_we,
    output logic [BITSADDR-1:0] mem_addr,
    output logic [BITSDATA-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [BITSDATA-1:0] mem_rdata
);

    mau_state_e          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [BITSDATA-1:0] load_data_q, load_data_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BITSADDR-1:0] mem_addr_q, mem_addr_d;
    logic [BITSDATA-1:0] mem_wdata_q, mem_wdata_d;
    logic                cnt_clear, cnt_enable, cnt_expired;
    logic [1:0]          op_sel;

    assign op_sel = memOP[1:0];

    mau_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        load_data_d = load_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!is_access(op_sel)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (address[1:0] != 2'b00) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op_sel == MOP_STORE);
                        mem_addr_d  = address;
                        mem_wdata_d = storeData;
                        cnt_clear   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // An ack arriving on the expiry cycle still wins over the timeout.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        load_data_d = mem_rdata;
                    end
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                end else if (cnt_expired) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    mem_req_d = 1'b0;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            load_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign loadData  = load_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected completions and memory
// requests are queued at issue time and checked by independent monitors.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;
    localparam int EW      = 49;   // {done cycle[15:0], error, loadData[31:0]}

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  memOP;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] loadData;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          never;
        logic [31:0] rdata;
        int          exp_cnt;
    } req_t;

    logic [EW-1:0] exp_q[$];
    req_t          req_q[$];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    mem_access_unit #(
        .BITSADDR (32),
        .BITSDATA (32),
        .MEMOP    (2),
        .TIMEOUT  (TIMEOUT),
        .CNTW     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .memOP     (memOP),
        .address   (address),
        .storeData (storeData),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .loadData  (loadData),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    // Start sampled at edge T = cyc+1; done expected visible at negedge with cyc = T+lat-1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int lat, input logic err, input logic [31:0] ld, input bit track);
        @(negedge clk);
        start     = 1'b1;
        memOP     = op;
        address   = a;
        storeData = d;
        if (track) exp_q.push_back({16'(cyc + lat), err, ld});
        @(negedge clk);
        start     = 1'b0;
        memOP     = 2'd0;
        address   = '0;
        storeData = '0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && req_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL drain_timeout: pending done %0d, pending req %0d", exp_q.size(), req_q.size());
        end
        @(negedge clk);
    endtask

    task automatic add_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input bit never, input logic [31:0] rd, input int cnt);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.waits = waits;
        r.never = never; r.rdata = rd; r.exp_cnt = cnt;
        req_q.push_back(r);
    endtask

    // ---------------- memory responder / request checker ----------------
    initial begin : responder
        req_t r;
        int   cnt;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                check("req_busy", busy, 1);
                if (req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_req: addr 0x%0h we %0b at cycle %0d", mem_addr, mem_we, cyc);
                    for (int i = 0; i < 64 && mem_req === 1'b1; i++) @(negedge clk);
                end else begin
                    r = req_q.pop_front();
                    check("req_we", mem_we, r.we);
                    check("req_addr", mem_addr, r.addr);
                    check("req_wdata", mem_wdata, r.wdata);
                    cnt = 1;
                    while (1) begin
                        if (!r.never && cnt - 1 == r.waits) begin
                            mem_ack   = 1'b1;
                            mem_rdata = r.rdata;
                        end
                        @(negedge clk);
                        mem_ack   = 1'b0;
                        mem_rdata = '0;
                        if (mem_req !== 1'b1 || cnt >= 64) break;
                        cnt++;
                    end
                    check("req_high_cycles", cnt, r.exp_cnt);
                end
            end
        end
    end

    // ---------------- completion monitor / scoreboard ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: error %0b loadData 0x%0h at cycle %0d", error, loadData, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e[48:33]);
                    check("done_error", error, e[32]);
                    check("done_loaddata", loadData, e[31:0]);
                    check("done_busy", busy, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        reset = 1'b1; start = 1'b0; memOP = 2'd0; address = '0; storeData = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_loaddata", loadData, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Load with two wait cycles: done at T+4.
        add_req(1'b0, 32'h0000_1004, 32'hAAAA_5555, 2, 1'b0, 32'hDEAD_BEEF, 3);
        issue(2'd1, 32'h0000_1004, 32'hAAAA_5555, 4, 1'b0, 32'hDEAD_BEEF, 1'b1);
        drain();

        // Zero-wait store: done at T+2, loadData untouched.
        add_req(1'b1, 32'h0000_0010, 32'h1234_5678, 0, 1'b0, 32'hFFFF_FFFF, 1);
        issue(2'd2, 32'h0000_0010, 32'h1234_5678, 2, 1'b0, 32'hDEAD_BEEF, 1'b1);
        drain();

        // Misaligned load: no request, error at T+1.
        issue(2'd1, 32'h0000_0006, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        drain();

        // Never acknowledged: mem_req high exactly TIMEOUT cycles.
        add_req(1'b0, 32'h0000_0100, 32'h0, 0, 1'b1, 32'h0, TIMEOUT);
        issue(2'd1, 32'h0000_0100, 32'h0, TIMEOUT + 1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        drain();

        // No-op codes, including reserved code on a misaligned address.
        issue(2'd0, 32'h0000_0020, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        drain();
        issue(2'd3, 32'h0000_0003, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        drain();

        // Ack on the final allowed cycle still succeeds.
        add_req(1'b0, 32'h0000_0200, 32'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, TIMEOUT);
        issue(2'd1, 32'h0000_0200, 32'h0, TIMEOUT + 1, 1'b0, 32'hCAFE_F00D, 1'b1);
        drain();

        // Start pulsed while in REQ must be ignored.
        add_req(1'b0, 32'h0000_0300, 32'h0, 3, 1'b0, 32'h0BAD_F00D, 4);
        issue(2'd1, 32'h0000_0300, 32'h0, 5, 1'b0, 32'h0BAD_F00D, 1'b1);
        start = 1'b1; memOP = 2'd0; address = 32'h0000_0040;
        @(negedge clk);
        start = 1'b0; address = '0;
        drain();

        // Reset in the middle of an access: request drops, no completion.
        add_req(1'b0, 32'h0000_0400, 32'h0, 0, 1'b1, 32'h0, 3);
        issue(2'd1, 32'h0000_0400, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_loaddata", loadData, 0);
        drain();

        // Normal traffic after the reset.
        add_req(1'b0, 32'h0000_0008, 32'h0, 1, 1'b0, 32'h55AA_55AA, 2);
        issue(2'd1, 32'h0000_0008, 32'h0, 3, 1'b0, 32'h55AA_55AA, 1'b1);
        drain();
        issue(2'd2, 32'h0000_0007, 32'h9999_9999, 1, 1'b1, 32'h55AA_55AA, 1'b1);
        drain();
        add_req(1'b1, 32'h0000_03FC, 32'h0F0F_0F0F, 5, 1'b0, 32'h1111_1111, 6);
        issue(2'd2, 32'h0000_03FC, 32'h0F0F_0F0F, 7, 1'b0, 32'h55AA_55AA, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        check("end_pending_done", exp_q.size(), 0);
        check("end_pending_req", req_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        n_checks++;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
